// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_if
//  Brief    : Bundle of request and control signals between the pipeline
//             stages and the pipeline sequencing controller.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
   parameter int CNT_W  = 6,
   parameter int PERF_W = 32
);
   // Requests coming from the pipeline stages
   logic              stallreq_id;
   logic              stallreq_ex;
   logic              stallreq_mem;
   logic              ex_mc_start;
   logic [CNT_W-1:0]  ex_mc_cycles;
   logic              flush_req;
   logic [31:0]       excp_pc;
   logic              cnt_clr;

   // Controls going back to the pipeline stages
   logic [5:0]        stall;
   logic              flush_o;
   logic [31:0]       new_pc_o;
   logic              ex_mc_done;
   logic              ex_mc_busy;
   logic [PERF_W-1:0] stall_cnt_o;

   // Pipeline side: raises requests, consumes hold/flush controls
   modport master (
      output stallreq_id, stallreq_ex, stallreq_mem,
      output ex_mc_start, ex_mc_cycles,
      output flush_req, excp_pc, cnt_clr,
      input  stall, flush_o, new_pc_o,
      input  ex_mc_done, ex_mc_busy, stall_cnt_o
   );

   // Controller side: consumes requests, produces hold/flush controls
   modport slave (
      input  stallreq_id, stallreq_ex, stallreq_mem,
      input  ex_mc_start, ex_mc_cycles,
      input  flush_req, excp_pc, cnt_clr,
      output stall, flush_o, new_pc_o,
      output ex_mc_done, ex_mc_busy, stall_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Pipeline sequencing controller for the 5-stage core.
//             Merges stage stall requests into one hold vector, sequences
//             multi-cycle EX operations, turns an exception into a one-cycle
//             flush with redirect PC, and counts stalled cycles.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
   parameter int CNT_W  = 6,
   parameter int PERF_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctrl_if.slave  bus
);

   // Hold patterns, bit order {wb,mem,ex,id,if,pc}
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MC_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              flush_q,  flush_d;
   logic [31:0]       new_pc_q, new_pc_d;
   logic [PERF_W-1:0] perf_q,   perf_d;

   logic              mc_stall_w;
   logic              mc_done_w;
   logic [5:0]        stall_w;

   // Next-state logic: flush has absolute priority and aborts any MC op
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flush_d    = 1'b0;
      new_pc_d   = new_pc_q;
      mc_stall_w = 1'b0;
      mc_done_w  = 1'b0;

      if (bus.flush_req) begin
         state_d  = ST_FLUSH;
         cnt_d    = '0;
         flush_d  = 1'b1;
         new_pc_d = bus.excp_pc;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.ex_mc_start) begin
                  if (bus.ex_mc_cycles > CNT_ONE) begin
                     // Start cycle is itself the first stalled cycle
                     state_d    = ST_MC_WAIT;
                     cnt_d      = bus.ex_mc_cycles - CNT_ONE;
                     mc_stall_w = 1'b1;
                  end else begin
                     // Zero/one-cycle ops complete immediately
                     mc_done_w  = 1'b1;
                  end
               end
            end
            ST_MC_WAIT: begin
               // New starts are ignored while an op is in flight
               if (cnt_q > CNT_ONE) begin
                  mc_stall_w = 1'b1;
                  cnt_d      = cnt_q - CNT_ONE;
               end else begin
                  mc_done_w  = 1'b1;
                  cnt_d      = '0;
                  state_d    = ST_RUN;
               end
            end
            ST_FLUSH: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are forced quiet while reset is held
      if (!rst_n) begin
         mc_stall_w = 1'b0;
         mc_done_w  = 1'b0;
      end
   end

   // Stall priority merge; the flush cycle itself releases every stage
   always_comb begin
      stall_w = STALL_NONE;
      if (!rst_n || state_q == ST_FLUSH) begin
         stall_w = STALL_NONE;
      end else if (bus.flush_req || bus.stallreq_mem) begin
         stall_w = STALL_MEM;
      end else if (bus.stallreq_ex || mc_stall_w) begin
         stall_w = STALL_EX;
      end else if (bus.stallreq_id) begin
         stall_w = STALL_ID;
      end
   end

   // Saturating stalled-cycle counter with clear taking priority
   always_comb begin
      perf_d = perf_q;
      if (bus.cnt_clr) begin
         perf_d = '0;
      end else if (stall_w[0] && (perf_q != PERF_MAX)) begin
         perf_d = perf_q + PERF_W'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         cnt_q    <= '0;
         flush_q  <= 1'b0;
         new_pc_q <= '0;
         perf_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
         perf_q   <= perf_d;
      end
   end

   assign bus.stall       = stall_w;
   assign bus.flush_o     = flush_q;
   assign bus.new_pc_o    = new_pc_q;
   assign bus.ex_mc_done  = mc_done_w;
   assign bus.ex_mc_busy  = (state_q == ST_MC_WAIT);
   assign bus.stall_cnt_o = perf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Brief    : Self-checking bench for pipe_ctrl. A cycle-number based model
//             predicts hold vector, MC done/busy, flush, redirect PC and the
//             stall counter; directed scenarios are followed by random ones.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

   localparam int CNT_W    = 6;
   localparam int PERF_W   = 4;
   localparam int PERF_MAX = (1 << PERF_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pipe_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

   pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: an MC op is described by the cycle number it finishes on
   int          cyc;
   bit          mc_active;
   int          done_at;
   bit          flush_now;
   logic [31:0] pc_exp;
   int          perf_exp;

   // Values sampled in the most recent cycle, for directed spot checks
   logic [5:0]        last_stall;
   logic              last_done;
   logic              last_busy;
   logic              last_flush;
   logic [31:0]       last_pc;
   logic [PERF_W-1:0] last_cnt;
   bit                saw_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc       = 0;
      mc_active = 1'b0;
      done_at   = 0;
      flush_now = 1'b0;
      pc_exp    = '0;
      perf_exp  = 0;
   endtask

   task automatic set_in(input bit id, input bit ex, input bit mem, input bit start,
                         input int n, input bit flush, input logic [31:0] pc, input bit clr);
      bus.stallreq_id  = id;
      bus.stallreq_ex  = ex;
      bus.stallreq_mem = mem;
      bus.ex_mc_start  = start;
      bus.ex_mc_cycles = CNT_W'(n);
      bus.flush_req    = flush;
      bus.excp_pc      = pc;
      bus.cnt_clr      = clr;
   endtask

   task automatic idle_in();
      set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
   endtask

   // One clock cycle: entered just after a rising edge with inputs applied
   task automatic cycle();
      bit         start_ok, mc_stall, done_e;
      int         n;
      logic [5:0] stall_e;

      n        = int'(bus.ex_mc_cycles);
      start_ok = !flush_now && !mc_active && bus.ex_mc_start && !bus.flush_req;
      mc_stall = (start_ok && n >= 2) || (mc_active && cyc < done_at);
      done_e   = !bus.flush_req && ((mc_active && cyc == done_at) || (start_ok && n <= 1));

      if (flush_now)                            stall_e = 6'b000000;
      else if (bus.flush_req || bus.stallreq_mem) stall_e = 6'b011111;
      else if (bus.stallreq_ex || mc_stall)     stall_e = 6'b001111;
      else if (bus.stallreq_id)                 stall_e = 6'b000111;
      else                                      stall_e = 6'b000000;

      @(negedge clk);
      last_stall = bus.stall;
      last_done  = bus.ex_mc_done;
      last_busy  = bus.ex_mc_busy;
      last_flush = bus.flush_o;
      last_pc    = bus.new_pc_o;
      last_cnt   = bus.stall_cnt_o;
      if (bus.ex_mc_done) saw_done = 1'b1;

      chk("stall",    64'(bus.stall),       64'(stall_e));
      chk("mc_done",  64'(bus.ex_mc_done),  64'(done_e));
      chk("mc_busy",  64'(bus.ex_mc_busy),  64'(mc_active));
      chk("flush_o",  64'(bus.flush_o),     64'(flush_now));
      chk("new_pc",   64'(bus.new_pc_o),    64'(pc_exp));
      chk("stall_cnt",64'(bus.stall_cnt_o), 64'(perf_exp));

      @(posedge clk);
      if (bus.cnt_clr)                           perf_exp = 0;
      else if (stall_e[0] && perf_exp < PERF_MAX) perf_exp = perf_exp + 1;

      if (bus.flush_req) begin
         flush_now = 1'b1;
         pc_exp    = bus.excp_pc;
         mc_active = 1'b0;
      end else begin
         flush_now = 1'b0;
         if (mc_active && cyc == done_at) begin
            mc_active = 1'b0;
         end else if (start_ok && n >= 2) begin
            mc_active = 1'b1;
            done_at   = cyc + n - 1;
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      idle_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 64'(bus.stall),       64'd0);
      chk("rst_busy",  64'(bus.ex_mc_busy),  64'd0);
      chk("rst_flush", 64'(bus.flush_o),     64'd0);
      chk("rst_cnt",   64'(bus.stall_cnt_o), 64'd0);
      rst_n = 1'b1;
      model_reset();

      // 1) idle after reset
      repeat (3) cycle();
      chk("t1_stall", 64'(last_stall), 64'd0);

      // 2) mem + id together, then id alone
      set_in(1, 0, 1, 0, 0, 0, 32'h0, 0);
      cycle();
      chk("t2_mem_id", 64'(last_stall), 64'h1f);
      set_in(1, 0, 0, 0, 0, 0, 32'h0, 0);
      cycle();
      chk("t2_id", 64'(last_stall), 64'h07);

      // 3) four-cycle MC op
      set_in(0, 0, 0, 0, 0, 0, 32'h0, 1);
      cycle();
      set_in(0, 0, 0, 1, 4, 0, 32'h0, 0);
      cycle();
      chk("t3_first", 64'(last_stall), 64'h0f);
      idle_in();
      repeat (2) cycle();
      cycle();
      chk("t3_done",  64'(last_done),  64'd1);
      chk("t3_stall", 64'(last_stall), 64'd0);
      chk("t3_cnt",   64'(last_cnt),   64'd3);

      // 4) one- and zero-cycle ops finish in their start cycle
      set_in(0, 0, 0, 1, 1, 0, 32'h0, 0);
      cycle();
      chk("t4_done1", 64'(last_done), 64'd1);
      set_in(0, 0, 0, 1, 0, 0, 32'h0, 0);
      cycle();
      chk("t4_done0", 64'(last_done), 64'd1);
      chk("t4_busy",  64'(last_busy), 64'd0);
      idle_in();
      cycle();

      // 5) flush on cycle 2 of a 10-cycle op
      saw_done = 1'b0;
      set_in(0, 0, 0, 1, 10, 0, 32'h0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 1, 32'h0000_0040, 0);
      cycle();
      idle_in();
      cycle();
      chk("t5_flush", 64'(last_flush), 64'd1);
      chk("t5_pc",    64'(last_pc),    64'h40);
      chk("t5_stall", 64'(last_stall), 64'd0);
      repeat (12) cycle();
      chk("t5_nodone", 64'(saw_done), 64'd0);
      chk("t5_pchold", 64'(last_pc),  64'h40);

      // 6) counter saturation, clear, then reset in the middle of an op
      set_in(1, 0, 0, 0, 0, 0, 32'h0, 0);
      repeat (PERF_MAX + 5) cycle();
      chk("t6_sat", 64'(last_cnt), 64'(PERF_MAX));
      set_in(0, 0, 0, 0, 0, 0, 32'h0, 1);
      cycle();
      idle_in();
      cycle();
      chk("t6_clr", 64'(last_cnt), 64'd0);
      set_in(0, 0, 0, 1, 20, 0, 32'h0, 0);
      cycle();
      idle_in();
      repeat (3) cycle();
      chk("t6_busy", 64'(last_busy), 64'd1);
      #2;
      rst_n = 1'b0;
      set_in(1, 1, 1, 1, 5, 0, 32'h0, 0);
      #1;
      chk("t6_rst_stall", 64'(bus.stall),       64'd0);
      chk("t6_rst_done",  64'(bus.ex_mc_done),  64'd0);
      chk("t6_rst_busy",  64'(bus.ex_mc_busy),  64'd0);
      chk("t6_rst_flush", 64'(bus.flush_o),     64'd0);
      chk("t6_rst_pc",    64'(bus.new_pc_o),    64'd0);
      chk("t6_rst_cnt",   64'(bus.stall_cnt_o), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      idle_in();
      rst_n = 1'b1;
      model_reset();

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         set_in(($urandom_range(3) == 0),
                ($urandom_range(7) == 0),
                ($urandom_range(7) == 0),
                ($urandom_range(3) == 0),
                int'($urandom_range(12)),
                ($urandom_range(15) == 0),
                $urandom,
                ($urandom_range(31) == 0));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
